// File: rtl/lcd_hd44780_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_hd44780_ctrl_if
// Brief    : Bus bundle between the IO-bank LCD word register and the
//            HD44780 controller (word in, LCD pins and debug status out).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface lcd_hd44780_ctrl_if;
  logic [31:0] lcd_word_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        lcd_blon_o;
  logic        busy_o;
  logic        done_o;

  // IO-bank side: owns the LCD word, observes pins/status
  modport master (
    output lcd_word_i,
    input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
    input  lcd_on_o, lcd_blon_o, busy_o, done_o
  );

  // Controller side
  modport slave (
    input  lcd_word_i,
    output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
    output lcd_on_o, lcd_blon_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_hd44780_ctrl
// Brief    : Turns changes of the 32-bit io_lcd word into timed HD44780
//            write cycles; runs power-up delay and 4-command init first.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_hd44780_ctrl #(
  parameter int T_PWR  = 750000,
  parameter int T_SU   = 2,
  parameter int T_EN   = 12,
  parameter int T_HOLD = 2,
  parameter int T_EXEC = 2000,
  parameter int T_CLR  = 82000,
  parameter int CNT_W  = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  lcd_hd44780_ctrl_if.slave   bus
);

  // Elaboration-time guard: every delay must be reachable by the counter.
  if ((T_PWR < 1) || (T_SU < 1) || (T_EN < 1) || (T_HOLD < 1) ||
      (T_EXEC < 1) || (T_CLR < 1) ||
      (64'(T_PWR)  > (64'd1 << CNT_W)) || (64'(T_SU)   > (64'd1 << CNT_W)) ||
      (64'(T_EN)   > (64'd1 << CNT_W)) || (64'(T_HOLD) > (64'd1 << CNT_W)) ||
      (64'(T_EXEC) > (64'd1 << CNT_W)) || (64'(T_CLR)  > (64'd1 << CNT_W)))
  begin : g_param_check
    $error("lcd_hd44780_ctrl: timing parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR  - 1);
  localparam logic [CNT_W-1:0] SU_LAST   = CNT_W'(T_SU   - 1);
  localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(T_EN   - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(T_CLR  - 1);

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_SETUP = 3'd1,
    S_EN    = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_IDLE  = 3'd5
  } state_e;

  // Fixed init program: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       idx_q,   idx_d;
  logic             init_q,  init_d;
  logic [10:0]      last_q,  last_d;
  logic [7:0]       data_q,  data_d;
  logic             rs_q,    rs_d;
  logic             en_q,    en_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             on_q,    blon_q;

  logic             slow_cmd;
  logic [CNT_W-1:0] wait_last;

  // Bits of the word the controller has no use for.
  logic unused_word_bits;
  assign unused_word_bits = ^bus.lcd_word_i[29:11];

  // Clear and home are the only slow instructions on the HD44780.
  assign slow_cmd  = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
  assign wait_last = slow_cmd ? CLR_LAST : EXEC_LAST;

  // Next-state, capture and status decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    init_d  = init_q;
    last_d  = last_q;
    data_d  = data_q;
    rs_d    = rs_q;
    done_d  = 1'b0;

    case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_SETUP;
          idx_d   = 2'd0;
          init_d  = 1'b1;
          data_d  = init_cmd(2'd0);
          rs_d    = 1'b0;
        end
      end
      S_SETUP: if (cnt_q == SU_LAST)   state_d = S_EN;
      S_EN:    if (cnt_q == EN_LAST)   state_d = S_HOLD;
      S_HOLD:  if (cnt_q == HOLD_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          if (init_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            data_d  = init_cmd(idx_q + 2'd1);
            rs_d    = 1'b0;
            state_d = S_SETUP;
          end else begin
            done_d  = !init_q;
            init_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        // Only the value present now counts; intermediate writes are dropped.
        if (bus.lcd_word_i[10:0] != last_q) begin
          last_d  = bus.lcd_word_i[10:0];
          data_d  = bus.lcd_word_i[7:0];
          rs_d    = bus.lcd_word_i[8];
          state_d = S_SETUP;
        end
      end
      default: state_d = S_PWR;
    endcase

    // Counter restarts on every state entry so each phase times from zero.
    cnt_d  = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    en_d   = (state_d == S_EN);
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and registered outputs; reset kills EN immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_PWR;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      init_q  <= 1'b1;
      last_q  <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
      blon_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      last_q  <= last_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      on_q    <= bus.lcd_word_i[31];
      blon_q  <= bus.lcd_word_i[30];
    end
  end

  assign bus.lcd_data_o = data_q;
  assign bus.lcd_rs_o   = rs_q;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = en_q;
  assign bus.lcd_on_o   = on_q;
  assign bus.lcd_blon_o = blon_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule
`default_nettype wire

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Downstream consumer of the LCD word register exported by the data-memory/IO bank (the 32-bit io_lcd word).
- Converts writes to that word into correctly timed HD44780 parallel bus cycles on the board's 16x2 character LCD.
- After reset, runs the power-on delay and a fixed four-command init sequence. It then watches the word and issues one bus write for each detected change.
- Firmware gets no handshake; the status outputs are for debug/LED use only.

Parameters:
- T_PWR, 750000, power-up wait in cycles (15 ms at 50 MHz).
- T_SU, 2, RS/data setup before EN rises, in cycles.
- T_EN, 12, EN high width in cycles.
- T_HOLD, 2, RS/data hold after EN falls, in cycles.
- T_EXEC, 2000, post-write wait for ordinary commands and data (40 us).
- T_CLR, 82000, post-write wait for clear (0x01) / home (0x02) commands with RS=0 (1.64 ms).
- CNT_W, 20, delay counter width; must hold max(T_*)-1.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- lcd_word_i  in  32  LCD word from IO bank:
  - [7:0] data/command byte
  - [8] RS
  - [10] repeat-toggle
  - [30] backlight
  - [31] power
  - other bits ignored.
- lcd_data_o  out  8  HD44780 DB[7:0].
- lcd_rs_o  out  1  register select.
- lcd_rw_o  out  1  read/write; tied 0 (write-only).
- lcd_en_o  out  1  enable strobe.
- lcd_on_o  out  1  registered lcd_word_i[31].
- lcd_blon_o  out  1  registered lcd_word_i[30].
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a user (non-init) transfer completes its wait.

Behaviour:
- Reset values:
  - state=PWR, counter=0, init index=0, last_q=0.
  - lcd_data_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0.
  - lcd_on_o=0, lcd_blon_o=0, busy_o=1, done_o=0.
- All outputs are registered. lcd_on_o and lcd_blon_o follow the word one cycle late in every state.
- States:
  - PWR: hold for T_PWR cycles, then go to SETUP with init cmd 0.
  - SETUP: drive data/RS, EN=0, for T_SU cycles.
  - EN: EN=1 for exactly T_EN cycles.
  - HOLD: EN=0, data/RS held, for T_HOLD cycles.
  - WAIT: T_CLR cycles if RS=0 and data is 0x01 or 0x02, else T_EXEC. Then:
    - if init index < 3: index++ and go to SETUP;
    - if index == 3 and still initialising: go to IDLE;
    - if user transfer: pulse done_o and go to IDLE.
  - IDLE: see trigger rule below.
- Init sequence, all with RS=0: 0x38, 0x0C, 0x01, 0x06. The 0x01 step uses T_CLR.
- The counter reloads to 0 on every state entry. The state advances on the cycle the counter equals T_x-1.
- Trigger rule in IDLE:
  - Transfer starts when lcd_word_i[10:0] != last_q[10:0].
  - On that edge, capture data and RS and set last_q[10:0] = lcd_word_i[10:0].
  - Next state is SETUP. lcd_data_o/lcd_rs_o are valid from the first SETUP cycle.
- Writing the same byte twice: firmware flips bit 10; the flip alone triggers a transfer.
- Word changes while busy (including during PWR/init) are not lost. Only the value present on return to IDLE is compared, so the latest value wins and intermediate values are dropped.
- Word equal to last_q in IDLE: no transfer. A word of 0 after reset therefore sends nothing.
- Latency: change visible in IDLE at cycle N → EN rises at edge N+1+T_SU.
- Back-to-back: after WAIT, IDLE lasts at least one cycle before the next SETUP.
- A reset asserted mid-transfer immediately forces EN=0 and all outputs to their reset values. The full power-up and init sequence then reruns.
- The counter never wraps: parameter checks require T_x ≥ 1 and T_x ≤ 2^CNT_W.

Test Plan (all use T_PWR=10, T_SU=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLR=8):
- Reset, hold word=0:
  - after 10 cycles, four EN pulses each 3 cycles wide, data 0x38/0x0C/0x01/0x06 with RS=0;
  - 8-cycle gap after 0x01;
  - busy_o falls; no done_o; no further EN.
- In IDLE, word=0x0000_0141:
  - EN high 3 cycles, starting 3 cycles after the change, with data=0x41, RS=1;
  - done_o pulses once, 5 cycles after EN-low+hold.
- After that write, keep the word the same, then flip bit 10 (0x0000_0541): exactly one more transfer of 0x41.
- Word=0x0000_0001 (RS=0 clear): post-wait is 8 cycles; done_o at the expected cycle.
- During an active transfer, write 0x142 then 0x143: after the current transfer, exactly one extra transfer with data 0x43.
- Assert rst_ni low during EN:
  - EN drops asynchronously, outputs return to reset values;
  - after release, the full PWR + init sequence repeats;
  - set bits 31/30: lcd_on_o/lcd_blon_o follow one cycle later, even while busy.
